simon_decrypt_control: RTL and testbench

//  Iterative SIMON decryptor: inverse of the encrypt controller, one inverse round per clock.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_inv_round.sv | 10 +
 rtl/simon_keyexpansion.sv | 24 ++
 rtl/simon_decrypt_control.sv | 126 ++++++++++++
 tb/tb_simon_decrypt_control.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared parameters, types and round functions for the iterative SIMON32/64 decryptor.
package simon_pkg;
  localparam int N  = 16;
  localparam int M  = 4;
  localparam int T  = 32;
  localparam int C  = 5;
  localparam int KW = $clog2(T);

  localparam logic [C:0] LAST = (C+1)'(T-1);

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;
  typedef logic [T-1:0][N-1:0] ks_t;
  typedef logic [M-1:0][N-1:0] key_t;

  // f(v) = (v<<<1 & v<<<8) ^ v<<<2
  function automatic logic [N-1:0] f(input logic [N-1:0] v);
    return ({v[N-2:0], v[N-1]} & {v[N-9:0], v[N-1:N-8]}) ^ {v[N-3:0], v[N-1:N-2]};
  endfunction

  function automatic logic [2*N-1:0] invround(input logic [2*N-1:0] blk, input logic [N-1:0] k);
    logic [N-1:0] x;
    logic [N-1:0] y;
    x = blk[2*N-1:N];
    y = blk[N-1:0];
    return {y, x ^ f(y) ^ k};
  endfunction
endpackage

// File: rtl/simon_inv_round.sv
// One combinational inverse SIMON round: {x,y} -> {y, x ^ f(y) ^ k}.
module simon_inv_round
  import simon_pkg::*;
(
  input  logic [2*N-1:0] block,
  input  logic [N-1:0]   key,
  output logic [2*N-1:0] out
);
  assign out = invround(block, key);
endmodule

// File: rtl/simon_keyexpansion.sv
// SIMON32/64 key-schedule step: next key word from k[i], k[i+1], k[i+3] and round index i.
module SIMON_keyexpansion
  import simon_pkg::*;
(
  input  logic [N-1:0] k0,
  input  logic [N-1:0] k1,
  input  logic [N-1:0] k3,
  input  logic [C:0]   round,
  output logic [N-1:0] kx_out
);
  // z0 constant sequence, first bit at the MSB
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  logic [N-1:0] tmp_a;
  logic [N-1:0] tmp_b;
  logic [5:0]   z_idx;

  always_comb begin
    z_idx  = 6'd61 - round;
    tmp_a  = {k3[2:0], k3[N-1:3]} ^ k1;
    tmp_b  = tmp_a ^ {tmp_a[0], tmp_a[N-1:1]};
    kx_out = ~k0 ^ tmp_b ^ {{(N-1){1'b0}}, Z0[z_idx]} ^ {{(N-2){1'b0}}, 2'b11};
  end
endmodule

// File: rtl/simon_decrypt_control.sv
// Iterative SIMON decryptor: expands the key once into a round-key store, then runs
// one inverse round per clock with round keys applied in reverse order.
//   state   | meaning
//   IDLE    | waiting for newData, no result yet
//   EXPAND  | writing one round key per clock into ks
//   DECRYPT | one inverse round per clock, keys ks[T-1] .. ks[0]
//   DONE    | plain valid, waiting for next newData
module simon_decrypt_control
  import simon_pkg::*;
(
  input  logic                  clk,
  input  logic                  nR,
  input  logic                  newData,
  input  logic                  newKey,
  input  logic [2*N-1:0]        cipher,
  input  logic [M-1:0][N-1:0]   key,
  output logic [2*N-1:0]        plain,
  output logic [C:0]            count,
  output logic                  done
);
  state_t          state_q, state_d;
  logic [C:0]      count_q, count_d;
  logic            done_q, done_d;
  logic [2*N-1:0]  plain_q, plain_d;
  logic            key_valid_q, key_valid_d;
  logic [2*N-1:0]  blk_q, blk_d;
  key_t            keys_q, keys_d;
  ks_t             ks_q, ks_d;

  logic [N-1:0]    kx_out;
  logic [2*N-1:0]  inv_out;
  logic [KW-1:0]   rk_idx;
  logic [KW-1:0]   wr_idx;

  assign wr_idx = count_q[KW-1:0];
  assign rk_idx = KW'(T-1) - count_q[KW-1:0];

  SIMON_keyexpansion u_kx (
    .k0     (keys_q[0]),
    .k1     (keys_q[1]),
    .k3     (keys_q[M-1]),
    .round  (count_q),
    .kx_out (kx_out)
  );

  simon_inv_round u_round (
    .block (blk_q),
    .key   (ks_q[rk_idx]),
    .out   (inv_out)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    done_d      = done_q;
    plain_d     = plain_q;
    key_valid_d = key_valid_q;
    blk_d       = blk_q;
    keys_d      = keys_q;
    ks_d        = ks_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (newData) begin
          blk_d   = cipher;
          keys_d  = key;
          count_d = '0;
          done_d  = 1'b0;
          state_d = (newKey || !key_valid_q) ? EXPAND : DECRYPT;
        end
      end
      EXPAND: begin
        ks_d[wr_idx] = keys_q[0];
        keys_d       = {kx_out, keys_q[M-1:1]};
        if (count_q == LAST) begin
          key_valid_d = 1'b1;
          count_d     = '0;
          state_d     = DECRYPT;
        end else begin
          count_d = count_q + (C+1)'(1);
        end
      end
      DECRYPT: begin
        blk_d = inv_out;
        // Last round lands straight in plain; count parks at T-1 until the next start.
        if (count_q == LAST) begin
          plain_d = inv_out;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          count_d = count_q + (C+1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q     <= IDLE;
      count_q     <= '0;
      done_q      <= 1'b0;
      plain_q     <= '0;
      key_valid_q <= 1'b0;
      blk_q       <= '0;
      keys_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      done_q      <= done_d;
      plain_q     <= plain_d;
      key_valid_q <= key_valid_d;
      blk_q       <= blk_d;
      keys_q      <= keys_d;
    end
  end

  // Key store needs no reset: key_valid_q guards its use.
  always_ff @(posedge clk) begin
    ks_q <= ks_d;
  end

  assign plain = plain_q;
  assign count = count_q;
  assign done  = done_q;
endmodule

// File: tb/tb_simon_decrypt_control.sv
// Randomized bench for simon_decrypt_control against a behavioural SIMON32/64 model.
module tb_simon_decrypt_control;
  localparam int T = 32;
  localparam logic [61:0] ZSEQ = 62'b11111010001001010110000111001101111101000100101011000011100110;

  logic                clk = 1'b0;
  logic                nR = 1'b1;
  logic                newData = 1'b0;
  logic                newKey = 1'b0;
  logic [31:0]         cipher = '0;
  logic [3:0][15:0]    key = '0;
  logic [31:0]         plain;
  logic [5:0]          count;
  logic                done;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  simon_decrypt_control dut (
    .clk     (clk),
    .nR      (nR),
    .newData (newData),
    .newKey  (newKey),
    .cipher  (cipher),
    .key     (key),
    .plain   (plain),
    .count   (count),
    .done    (done)
  );

  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return 16'((v << s) | (v >> (16 - s)));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int s);
    return 16'((v >> s) | (v << (16 - s)));
  endfunction

  function automatic logic [15:0] ff(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic logic [31:0][15:0] sched(input logic [3:0][15:0] k);
    logic [15:0] w [36];
    logic [15:0] t;
    logic [61:0] z;
    logic [31:0][15:0] r;
    z = ZSEQ;
    for (int i = 0; i < 4; i++) w[i] = k[i];
    for (int i = 0; i < 32; i++) begin
      t = ror(w[i+3], 3) ^ w[i+1];
      t = t ^ ror(t, 1);
      w[i+4] = 16'hfffc ^ w[i] ^ t ^ {15'b0, z[61-i]};
    end
    for (int i = 0; i < 32; i++) r[i] = w[i];
    return r;
  endfunction

  function automatic logic [31:0] encrypt(input logic [31:0] p, input logic [31:0][15:0] ks);
    logic [15:0] x, y, t;
    x = p[31:16]; y = p[15:0];
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ ff(x) ^ ks[r];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] decrypt(input logic [31:0] c, input logic [31:0][15:0] ks);
    logic [15:0] x, y, t;
    x = c[31:16]; y = c[15:0];
    for (int r = 31; r >= 0; r--) begin
      t = y;
      y = x ^ ff(y) ^ ks[r];
      x = t;
    end
    return {x, y};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is just "total edges to go" plus a precomputed answer.
  logic              m_done;
  logic [31:0]       m_plain;
  int                m_count;
  bit                m_busy, m_kv, m_exp;
  int                m_e, m_total;
  logic [31:0]       m_result;
  logic [31:0][15:0] m_ks;

  always @(posedge clk or negedge nR) begin
    if (!nR) begin
      m_done = 1'b0; m_plain = '0; m_count = 0; m_busy = 1'b0; m_kv = 1'b0;
    end else if (!m_busy) begin
      if (newData) begin
        m_exp = newKey || !m_kv;
        if (m_exp) m_ks = sched(key);
        m_result = decrypt(cipher, m_ks);
        m_total  = m_exp ? 2*T : T;
        m_e = 0; m_busy = 1'b1; m_done = 1'b0; m_count = 0;
      end
    end else begin
      m_e++;
      if (m_exp && m_e == T) m_kv = 1'b1;
      if (m_e == m_total) begin
        m_busy = 1'b0; m_done = 1'b1; m_plain = m_result; m_count = T - 1;
      end else begin
        m_count = m_e % T;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && nR) begin
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_plain", plain, m_plain);
      chk("cyc_count", {26'b0, count}, 32'(m_count));
    end
  end

  task automatic run(input logic [31:0] c, input logic [3:0][15:0] k, input bit nk,
                     input int pulse_at, input int rst_at,
                     output logic [31:0] p, output int lat);
    @(negedge clk);
    cipher = c; key = k; newKey = nk; newData = 1'b1;
    @(negedge clk);
    newData = 1'b0; newKey = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (newData) begin newData = 1'b0; newKey = 1'b0; end
      if (lat == rst_at) begin
        nR = 1'b0; #2; nR = 1'b1;
        p = plain;
        return;
      end
      if (done) break;
      if (lat == pulse_at) begin newData = 1'b1; newKey = 1'b1; cipher = ~c; end
    end
    p = plain;
    if (!done) chk("done_timeout", 32'(lat), 32'd0);
  endtask

  localparam logic [3:0][15:0] K0 = {16'h1918, 16'h1110, 16'h0908, 16'h0100};

  initial begin
    logic [31:0]      p, pt, ct;
    logic [3:0][15:0] kk;
    int               lat;
    bit               nk;

    // reset asserted mid-clock takes effect immediately
    #3 nR = 1'b0;
    #1;
    chk("rst_plain", plain, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_count", {26'b0, count}, 32'h0);
    #8 nR = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_done", {31'b0, done}, 32'h0);
    chk("idle_count", {26'b0, count}, 32'h0);

    chk("model_vec", decrypt(32'hc69be9bb, sched(K0)), 32'h65656877);
    chk("model_enc", encrypt(32'h65656877, sched(K0)), 32'hc69be9bb);

    run(32'hc69be9bb, K0, 1'b1, 0, 0, p, lat);
    chk("vec_plain", p, 32'h65656877);
    chk("vec_lat", 32'(lat), 32'd64);

    run(32'hc69be9bb, K0, 1'b0, 0, 0, p, lat);
    chk("reuse_plain", p, 32'h65656877);
    chk("reuse_lat", 32'(lat), 32'd32);

    run(32'hc69be9bb, K0, 1'b0, 10, 0, p, lat);
    chk("ign_plain", p, 32'h65656877);
    chk("ign_lat", 32'(lat), 32'd32);

    // back-to-back: newData held high across completions
    @(negedge clk);
    cipher = 32'hc69be9bb; key = K0; newKey = 1'b0; newData = 1'b1;
    repeat (80) @(negedge clk);
    newData = 1'b0;
    repeat (40) @(negedge clk);
    chk("b2b_done", {31'b0, done}, 32'h1);
    chk("b2b_plain", plain, 32'h65656877);

    // reset mid-EXPAND, then a newKey=0 start must still expand
    run(32'hc69be9bb, K0, 1'b1, 0, 10, p, lat);
    @(negedge clk);
    chk("midrst_plain", plain, 32'h0);
    run(32'hc69be9bb, K0, 1'b0, 0, 0, p, lat);
    chk("midrst_res", p, 32'h65656877);
    chk("midrst_lat", 32'(lat), 32'd64);

    // random round trips; newKey=0 keeps the previous key
    kk = K0;
    for (int i = 0; i < 100; i++) begin
      nk = ($urandom_range(1) == 1);
      if (nk) kk = {$urandom, $urandom};
      pt = $urandom;
      ct = encrypt(pt, sched(kk));
      run(ct, kk, nk, 0, 0, p, lat);
      chk("rt_plain", p, pt);
      chk("rt_lat", 32'(lat), nk ? 32'd64 : 32'd32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
